// File: rtl/alu_pkg.sv
// alu_pkg: opcode values, field widths and FSM encoding shared by the ALU share arbiter.
package alu_pkg;
    localparam int OPW = 4;
    localparam int SHW = 5;
    localparam logic [OPW-1:0] ADD  = 4'd0;
    localparam logic [OPW-1:0] SUB  = 4'd1;
    localparam logic [OPW-1:0] AND  = 4'd2;
    localparam logic [OPW-1:0] OR   = 4'd3;
    localparam logic [OPW-1:0] SLL  = 4'd4;
    localparam logic [OPW-1:0] SEQ  = 4'd5;
    localparam logic [OPW-1:0] NOR  = 4'd6;
    localparam logic [OPW-1:0] SGT  = 4'd7;
    localparam logic [OPW-1:0] SLTU = 4'd8;
    localparam logic [OPW-1:0] SRA  = 4'd9;
    localparam logic [OPW-1:0] MUL  = 4'd10;
    localparam logic [OPW-1:0] SGE  = 4'd11;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    function automatic logic is_illegal(input logic [OPW-1:0] op);
        return (op inside {SEQ, SGT, SLTU, SGE}) || (op >= 4'd12);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or after the pointer.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx
);
    // Scan farthest-first so the candidate nearest the pointer is the last to overwrite.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_grant = NREQ'(1) << ((int'(i_ptr) + k) % NREQ);
                o_idx   = PW'((int'(i_ptr) + k) % NREQ);
            end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ requesters.
// Optional illegal-opcode flagging is built when ALU_SHARE_ILLEGAL_CHK_EN is defined.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MUL_WAIT = 1,
    parameter int IDW      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OPW*NREQ-1:0]   req_opcode,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    input  logic [SHW*NREQ-1:0]   req_shamt,
    output logic [OPW-1:0]        alu_opcode,
    output logic [WIDTH-1:0]      alu_input1,
    output logic [WIDTH-1:0]      alu_input2,
    output logic [SHW-1:0]        alu_shiftValue,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_carryFlag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_carry,
    output logic                  rsp_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MUL_WAIT + 2);
    state_t          r_state, w_next;
    logic [PW-1:0]   r_ptr, w_idx;
    logic [NREQ-1:0] w_grant;
    logic [CW-1:0]   r_cnt;
    logic [OPW-1:0]  w_op;
    logic            r_err, w_hs, w_illegal, w_done;
    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .i_req(req_valid),
        .i_ptr(r_ptr),
        .o_grant(w_grant),
        .o_idx(w_idx)
    );
    assign req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
    assign w_hs      = |req_ready;
    assign w_op      = req_opcode[OPW*w_idx +: OPW];
    assign w_done    = r_cnt == '0;
`ifdef ALU_SHARE_ILLEGAL_CHK_EN
    assign w_illegal = is_illegal(w_op);
    assign rsp_err   = r_err;
`else
    assign w_illegal = 1'b0;
    assign rsp_err   = 1'b0;
`endif
    always_comb begin
        w_next = r_state == IDLE ? (w_hs ? EXEC : IDLE) :
                 r_state == EXEC ? (w_done ? RESP : EXEC) :
                 (rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_err          <= 1'b0;
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_result     <= '0;
            rsp_carry      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_hs) begin
                alu_opcode     <= w_op;
                alu_input1     <= req_a[WIDTH*w_idx +: WIDTH];
                alu_input2     <= req_b[WIDTH*w_idx +: WIDTH];
                alu_shiftValue <= req_shamt[SHW*w_idx +: SHW];
                rsp_id         <= IDW'(w_idx);
                r_ptr          <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                r_cnt          <= (w_op == MUL) ? CW'(MUL_WAIT) : '0;
                r_err          <= w_illegal;
            end
            if (r_state == EXEC) begin
                if (w_done) begin
                    rsp_result <= r_err ? '0 : alu_result;
                    rsp_carry  <= !r_err && alu_carryFlag;
                    rsp_valid  <= 1'b1;
                end else
                    r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                r_err     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors plus round-robin, backpressure and reset sequences.
module tb_alu_share_arbiter;
    import alu_pkg::*;
    localparam int N = 4;
    localparam int W = 8;
`ifdef ALU_SHARE_ILLEGAL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid, req_ready;
    logic [4*N-1:0] req_opcode;
    logic [W*N-1:0] req_a, req_b;
    logic [5*N-1:0] req_shamt;
    logic [3:0]     alu_opcode;
    logic [W-1:0]   alu_input1, alu_input2, alu_result, rsp_result;
    logic [4:0]     alu_shiftValue;
    logic           alu_carryFlag, rsp_valid, rsp_ready, rsp_carry, rsp_err;
    logic [1:0]     rsp_id;
    logic [8:0]     m_res;
    int             n_vec = 0;
    int             n_bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    always_comb begin
        case (alu_opcode)
            ADD:     m_res = {1'b0, alu_input1} + {1'b0, alu_input2};
            SUB:     m_res = {1'b0, alu_input1} - {1'b0, alu_input2};
            AND:     m_res = {1'b0, alu_input1 & alu_input2};
            OR:      m_res = {1'b0, alu_input1 | alu_input2};
            SLL:     m_res = {1'b0, 8'(alu_input1 << alu_shiftValue)};
            SEQ:     m_res = {8'b0, alu_input1 == alu_input2};
            NOR:     m_res = {1'b0, ~(alu_input1 | alu_input2)};
            SGT:     m_res = {8'b0, $signed(alu_input1) > $signed(alu_input2)};
            SLTU:    m_res = {8'b0, alu_input1 < alu_input2};
            SRA:     m_res = {1'b0, 8'($signed(alu_input1) >>> alu_shiftValue)};
            MUL:     m_res = {1'b0, 8'(alu_input1 * alu_input2)};
            SGE:     m_res = {8'b0, $signed(alu_input1) >= $signed(alu_input2)};
            default: m_res = 9'h0;
        endcase
    end
    assign alu_result    = m_res[7:0];
    assign alu_carryFlag = m_res[8];

    typedef struct {
        int         id;
        logic [3:0] op;
        logic [7:0] a, b;
        logic [4:0] sh;
        logic [7:0] res;
        logic       cy, err;
        int         lat;
    } vec_t;
    vec_t v[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [4:0] sh);
        req_opcode[4*id +: 4] = op;
        req_a[8*id +: 8]      = a;
        req_b[8*id +: 8]      = b;
        req_shamt[5*id +: 5]  = sh;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_op(input vec_t x);
        int n;
        set_req(x.id, x.op, x.a, x.b, x.sh);
        req_valid = '0;
        req_valid[x.id] = 1'b1;
        #1;
        chk("grant", 32'(req_ready), 32'(1) << x.id);
        step();
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            chk("alu_op_hold", 32'(alu_opcode), 32'(x.op));
            step();
            n++;
        end
        chk("latency", n, x.lat);
        chk("rsp_id", 32'(rsp_id), x.id);
        chk("rsp_result", 32'(rsp_result), 32'(x.res));
        chk("rsp_carry", 32'(rsp_carry), 32'(x.cy));
        chk("rsp_err", 32'(rsp_err), 32'(x.err));
        chk("alu_a_hold", 32'(alu_input1), 32'(x.a));
        step();
        chk("rsp_drop", 32'(rsp_valid), 0);
    endtask

    initial begin
        int n, gi, last;
        int order[5];
        int gcyc[5];
        int got;
        v[0] = '{0, ADD,      8'hF0, 8'h20, 5'd0, 8'h10, 1'b1, 1'b0, 2};
        v[1] = '{1, SUB,      8'h05, 8'h07, 5'd0, 8'hFE, 1'b1, 1'b0, 2};
        v[2] = '{2, MUL,      8'h03, 8'h05, 5'd0, 8'h0F, 1'b0, 1'b0, 3};
        v[3] = '{3, AND,      8'hF0, 8'h3C, 5'd0, 8'h30, 1'b0, 1'b0, 2};
        v[4] = '{1, SLL,      8'h81, 8'h00, 5'd1, 8'h02, 1'b0, 1'b0, 2};
        v[5] = '{0, OR,       8'h0F, 8'hA0, 5'd0, 8'hAF, 1'b0, 1'b0, 2};
        v[6] = '{3, 4'd13,    8'h12, 8'h34, 5'd0, 8'h00, 1'b0, CHK,  2};
        v[7] = '{2, SEQ,      8'h05, 8'h05, 5'd0, CHK ? 8'h00 : 8'h01, 1'b0, CHK, 2};
        v[8] = '{0, MUL,      8'h10, 8'h10, 5'd0, 8'h00, 1'b0, 1'b0, 3};
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        req_shamt  = '0;
        rsp_ready  = 1'b1;
        req_valid  = '1;
        rst        = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_alu_op", 32'(alu_opcode), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        req_valid = '0;
        rst = 1'b0;
        step();
        foreach (v[i]) run_op(v[i]);

        pulse_rst();
        for (int i = 0; i < N; i++) set_req(i, ADD, 8'(i), 8'h01, 5'd0);
        req_valid = '1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
                order[got] = gi;
                gcyc[got] = c;
                got++;
            end
            step();
        end
        req_valid = '0;
        chk("rr_count", got, 5);
        for (int i = 0; i < got; i++) begin
            chk("rr_order", order[i], i % N);
            if (i > 0) chk("rr_gap", gcyc[i] - gcyc[i-1], 3);
        end
        repeat (4) step();

        pulse_rst();
        rsp_ready = 1'b0;
        set_req(0, ADD, 8'hF0, 8'h20, 5'd0);
        set_req(1, ADD, 8'h01, 8'h02, 5'd0);
        req_valid = 4'b0011;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0010;
        wait_rsp(n);
        chk("bp_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", 32'(rsp_valid), 1);
            chk("bp_result_hold", 32'(rsp_result), 32'h10);
            chk("bp_ready_low", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(rsp_valid), 0);
        chk("bp_next_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        wait_rsp(n);
        chk("bp_next_id", 32'(rsp_id), 1);
        chk("bp_next_result", 32'(rsp_result), 32'h03);
        step();

        pulse_rst();
        set_req(1, SUB, 8'h09, 8'h04, 5'd3);
        set_req(3, ADD, 8'h01, 8'h01, 5'd0);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        chk("mid_alu_op", 32'(alu_opcode), 32'(SUB));
        rst = 1'b1;
        step();
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_alu_op_clr", 32'(alu_opcode), 0);
        chk("mid_alu_a_clr", 32'(alu_input1), 0);
        chk("mid_alu_sh_clr", 32'(alu_shiftValue), 0);
        chk("mid_rsp_id_clr", 32'(rsp_id), 0);
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("mid_regrant", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1000;
        wait_rsp(n);
        chk("mid_id", 32'(rsp_id), 1);
        chk("mid_result", 32'(rsp_result), 32'h05);
        step();
        #1;
        chk("mid_next_grant", 32'(req_ready), 32'b1000);
        req_valid = '0;
        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
